// File: rtl/tc_io_pkg.sv
// Shared types for the digital I/O controller.
//   lane_cfg_t   : per-lane pad configuration written through the config port.
//   lane_state_e : per-lane sequencing state (IDLE or TURN).
//   LaneCfgRst   : lane configuration after reset (high-Z, no pulls, no irq).
package tc_io_pkg;

  typedef struct packed {
    logic       out;
    logic       oe;
    logic [3:0] strength;
    logic       pu;
    logic       pd;
    logic       irq_rise_en;
    logic       irq_fall_en;
  } lane_cfg_t;

  typedef enum logic {
    IDLE = 1'b0,
    TURN = 1'b1
  } lane_state_e;

  localparam lane_cfg_t LaneCfgRst = '0;

endpackage

// File: rtl/tc_io_debounce.sv
// Input conditioning for one pad lane: multi-flop synchroniser, debounce
// counter against a live threshold, stable level and one-cycle edge pulses.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   pad_i        : asynchronous pad input
//   thresh_i     : debounce threshold in cycles (sampled every cycle)
//   level_o      : debounced level
//   rise_o/fall_o: one-cycle pulse coincident with the first cycle of a new level
module tc_io_debounce #(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned DebounceW  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pad_i,
  input  logic [DebounceW-1:0] thresh_i,
  output logic                 level_o,
  output logic                 rise_o,
  output logic                 fall_o
);

  function automatic logic [DebounceW-1:0] sat_inc(input logic [DebounceW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [SyncStages-1:0] sync_p0;
  logic                  sync;
  logic [DebounceW-1:0]  cnt_p1;
  logic                  stable_p1;
  logic                  rise_p1;
  logic                  fall_p1;
  logic                  flip;

  // Stage 0: synchroniser chain, oldest sample at the top bit
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_p0 <= '0;
    else       sync_p0 <= {sync_p0[SyncStages-2:0], pad_i};
  end

  assign sync = sync_p0[SyncStages-1];

  // >= rather than == so a threshold lowered below the running count still
  // commits on the next mismatching cycle.
  assign flip = (sync != stable_p1) && (cnt_p1 >= thresh_i);

  // Stage 1: debounce counter, stable level and edge pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_p1    <= '0;
      stable_p1 <= 1'b0;
      rise_p1   <= 1'b0;
      fall_p1   <= 1'b0;
    end else begin
      rise_p1 <= flip & sync;
      fall_p1 <= flip & ~sync;
      if (sync == stable_p1) begin
        cnt_p1 <= '0;
      end else if (flip) begin
        stable_p1 <= sync;
        cnt_p1    <= '0;
      end else begin
        cnt_p1 <= sat_inc(cnt_p1);
      end
    end
  end

  assign level_o = stable_p1;
  assign rise_o  = rise_p1;
  assign fall_o  = fall_p1;

endmodule

// File: rtl/tc_digital_io_ctrl.sv
// Core-side controller for a bank of tc_digital_io pad cells.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   cfg_valid_i/cfg_ready_o : lane config write handshake
//   cfg_idx_i, cfg_i        : target lane and new configuration
//   debounce_i              : global debounce threshold (cycles)
//   irq_clr_i               : per-lane sticky interrupt clear
//   level_o, rise_o, fall_o : debounced level and edge pulses
//   irq_o                   : sticky per-lane interrupt
//   pad_*_o                 : drive controls to the pads
//   pad_data_i              : asynchronous pad input (includes own-output loopback)
module tc_digital_io_ctrl
  import tc_io_pkg::*;
#(
  parameter  int unsigned NumIo      = 8,
  parameter  int unsigned SyncStages = 2,
  parameter  int unsigned DebounceW  = 8,
  parameter  int unsigned TurnCycles = 1,
  localparam int unsigned IdxW       = (NumIo > 1) ? $clog2(NumIo) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  logic [IdxW-1:0]           cfg_idx_i,
  input  lane_cfg_t                 cfg_i,
  input  logic [DebounceW-1:0]      debounce_i,
  input  logic [NumIo-1:0]          irq_clr_i,
  output logic [NumIo-1:0]          level_o,
  output logic [NumIo-1:0]          rise_o,
  output logic [NumIo-1:0]          fall_o,
  output logic [NumIo-1:0]          irq_o,
  output logic [NumIo-1:0]          pad_data_o,
  output logic [NumIo-1:0]          pad_oe_no,
  output logic [NumIo-1:0][3:0]     pad_strength_o,
  output logic [NumIo-1:0]          pad_pu_o,
  output logic [NumIo-1:0]          pad_pd_o,
  input  logic [NumIo-1:0]          pad_data_i
);

  localparam int unsigned TcW = $clog2(TurnCycles + 1);

  lane_state_e    state_q [NumIo];
  lane_state_e    state_d [NumIo];
  logic [TcW-1:0] turn_q  [NumIo];
  logic [TcW-1:0] turn_d  [NumIo];
  lane_cfg_t      cfg_q   [NumIo];
  lane_cfg_t      cfg_d   [NumIo];
  logic           sel_idle;
  logic           wr;
  logic [NumIo-1:0] irq_set;
  logic [NumIo-1:0] irq_p2;

  // Out-of-range indices match no lane, so they are always ready and ignored.
  always_comb begin
    sel_idle = 1'b1;
    for (int i = 0; i < NumIo; i++) begin
      if (cfg_idx_i == IdxW'(i)) sel_idle = (state_q[i] == IDLE);
    end
  end

  assign cfg_ready_o = !rst_i && sel_idle;

  always_comb begin
    wr = 1'b0;
    for (int i = 0; i < NumIo; i++) begin
      state_d[i] = state_q[i];
      turn_d[i]  = turn_q[i];
      cfg_d[i]   = cfg_q[i];
      wr = cfg_valid_i && cfg_ready_o && (cfg_idx_i == IdxW'(i));
      unique case (state_q[i])
        IDLE: begin
          if (wr) begin
            cfg_d[i] = cfg_i;
            // Input -> output: hold high-Z so the external driver can let go.
            if (!cfg_q[i].oe && cfg_i.oe) begin
              state_d[i] = TURN;
              turn_d[i]  = TcW'(TurnCycles);
            end
          end
        end
        TURN: begin
          if (turn_q[i] <= TcW'(1)) begin
            state_d[i] = IDLE;
            turn_d[i]  = '0;
          end else begin
            turn_d[i] = turn_q[i] - TcW'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Stage 1: lane configuration and sequencing state
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumIo; i++) begin
      if (rst_i) begin
        state_q[i] <= IDLE;
        turn_q[i]  <= '0;
        cfg_q[i]   <= LaneCfgRst;
      end else begin
        state_q[i] <= state_d[i];
        turn_q[i]  <= turn_d[i];
        cfg_q[i]   <= cfg_d[i];
      end
    end
  end

  genvar g;
  for (g = 0; g < NumIo; g++) begin : g_lane
    // Enabling only one of the pulls; both requested means neither.
    assign pad_data_o[g]     = cfg_q[g].out;
    assign pad_oe_no[g]      = !(cfg_q[g].oe && (state_q[g] == IDLE));
    assign pad_strength_o[g] = cfg_q[g].strength;
    assign pad_pu_o[g]       = cfg_q[g].pu & ~cfg_q[g].pd;
    assign pad_pd_o[g]       = cfg_q[g].pd & ~cfg_q[g].pu;

    tc_io_debounce #(
      .SyncStages(SyncStages),
      .DebounceW (DebounceW)
    ) u_debounce (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pad_i   (pad_data_i[g]),
      .thresh_i(debounce_i),
      .level_o (level_o[g]),
      .rise_o  (rise_o[g]),
      .fall_o  (fall_o[g])
    );

    assign irq_set[g] = (rise_o[g] & cfg_q[g].irq_rise_en) |
                        (fall_o[g] & cfg_q[g].irq_fall_en);
  end

  // Stage 2: sticky interrupts, set dominates clear
  always_ff @(posedge clk_i) begin
    if (rst_i) irq_p2 <= '0;
    else       irq_p2 <= (irq_p2 & ~irq_clr_i) | irq_set;
  end

  assign irq_o = irq_p2;

endmodule

// File: doc/tc_digital_io_ctrl.md
Name: tc_digital_io_ctrl

Overview:
- Digital core-side controller for a bank of NumIo `tc_digital_io` pad cells.
- Registers per-lane drive configuration from a valid/ready config port and drives each pad's `data_i`, `io_direction_oe_ni`, `io_driving_strength_i`, `io_pullup_en_i` and `io_pulldown_en_i`.
- Inserts a high-Z turnaround before a lane starts driving.
- Synchronises and debounces each pad's `data_o`, and produces level, edge-pulse and sticky-interrupt outputs for the core.

Parameters:
- NumIo, 8, number of pad lanes (1..32).
- SyncStages, 2, flops in the input synchroniser (>=2).
- DebounceW, 8, width of the debounce counter and threshold.
- TurnCycles, 1, high-Z cycles inserted when a lane switches from input to output (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- cfg_valid_i  in  1  config write request.
- cfg_ready_o  out  1  config write accepted when valid&ready.
- cfg_idx_i  in  $clog2(NumIo) (min 1)  target lane.
- cfg_i  in  lane_cfg_t  new lane configuration.
- debounce_i  in  DebounceW  global debounce threshold, in cycles.
- irq_clr_i  in  NumIo  per-lane sticky interrupt clear.
- level_o  out  NumIo  debounced input level.
- rise_o  out  NumIo  one-cycle pulse on a debounced 0->1 change.
- fall_o  out  NumIo  one-cycle pulse on a debounced 1->0 change.
- irq_o  out  NumIo  sticky interrupt.
- pad_data_o  out  NumIo  to pad `data_i`.
- pad_oe_no  out  NumIo  to pad `io_direction_oe_ni`.
- pad_strength_o  out  NumIo x 4  to pad `io_driving_strength_i`.
- pad_pu_o  out  NumIo  to pad `io_pullup_en_i`.
- pad_pd_o  out  NumIo  to pad `io_pulldown_en_i`.
- pad_data_i  in  NumIo  from pad `data_o`; asynchronous.

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - pad_oe_no all 1; pad_data_o, pad_pu_o, pad_pd_o, level_o, rise_o, fall_o, irq_o all 0; pad_strength_o 4'h0.
  - All lanes go to IDLE. Synchroniser flops, stable levels and debounce counters clear to 0.
  - cfg_ready_o is 0 while rst_i is high.
  - Reset during TURN aborts the turnaround and the lane returns to high-Z.
- Lane state machine:
  - States: IDLE and TURN.
  - cfg_ready_o = !rst_i && (state[cfg_idx_i]==IDLE). An index >= NumIo is accepted and ignored.
  - Accepted write, old oe=0 (input) and new oe=1 (drive): lane enters TURN with a counter of TurnCycles. pad_oe_no stays 1 and pad_data_o takes the new value. After TurnCycles cycles the lane returns to IDLE and pad_oe_no goes to 0 on the next edge.
  - Any other accepted write: all fields are registered and visible at the pad on the next edge (latency 1).
  - In TURN, strength and pull fields already apply.
- Pull rule: if pu and pd are both 1 in cfg_i, both pad_pu_o and pad_pd_o are driven 0 for that lane.
- Input path, per lane:
  - pad_data_i passes through SyncStages flops to give `sync`.
  - Debounce compares `sync` to `stable`:
    - Equal: cnt <= 0.
    - Differ and cnt==debounce_i: stable <= sync, cnt <= 0.
    - Otherwise: cnt <= cnt+1 (saturating).
  - level_o = stable.
  - Latency from a pad change to level_o is SyncStages+1+debounce_i cycles. With debounce_i=0, a change of one cycle or longer that survives synchronisation propagates.
  - A glitch shorter than debounce_i+1 synchronised cycles produces no change.
  - debounce_i is sampled live. Lowering it mid-count applies the new threshold immediately; if cnt already exceeds it, the update happens on the next mismatching cycle.
- Edge pulses: rise_o/fall_o assert for exactly the one cycle after `stable` changes.
- Interrupts:
  - irq set when (rise & irq_rise_en) | (fall & irq_fall_en).
  - irq_clr_i clears the bit; set wins over clear in the same cycle.
- Outputs are always sensed: a driving lane observes its own output through the pad loopback.

Decomposition:
- Package `tc_io_pkg`:
  - lane_cfg_t packed struct: out, oe, strength[3:0], pu, pd, irq_rise_en, irq_fall_en.
  - lane_state_e enum {IDLE, TURN}.
  - Reset constant LaneCfgRst.
- Sub-module `tc_io_debounce`: synchroniser, counter, stable register and edge pulses for one lane. The top module instantiates it NumIo times.

Test Plan:
- Reset: assert rst_i for 3 cycles, then release -> all pad_oe_no=1, pulls and irq 0, cfg_ready_o=1 on the first cycle after release.
- Turnaround: lane 2 input; write oe=1, out=1 -> pad_data_o[2]=1 next edge, pad_oe_no[2]=1 for 1 cycle, then 0. cfg_ready_o is 0 for lane 2 during TURN and 1 for lane 3.
- Direct write: lane 0 driving; write out=0, strength=4'hA -> both visible 1 cycle later, no TURN. Write pu=1, pd=1 -> both pulls 0.
- Debounce: debounce_i=4, raise pad_data_i[1] for 3 cycles -> level_o unchanged. Hold it high -> level_o=1 exactly 2+1+4=7 cycles after the rise, with rise_o a single-cycle pulse.
- IRQ: irq_fall_en=1 on lane 5; falling edge -> irq_o[5] latched. Pulse irq_clr_i[5] in the same cycle as a second fall -> irq_o[5] stays 1. A later clear -> 0.
- Reset mid-TURN: with TurnCycles=4, assert rst_i at the 2nd TURN cycle -> pad_oe_no=1, lane IDLE, and the prior config is discarded.
